// File: rtl/ad9945_pkg.sv
// ad9945_pkg: shared constants and types for the AD9945 serial interface
package ad9945_pkg;
    localparam int ADDR_W     = 3;
    localparam int WORD_W     = 12;
    localparam int FRAME_BITS = 63;
    localparam int OPER_W     = 7;
    localparam int CTRL_W     = 7;
    localparam int CLAMP_W    = 8;
    localparam int VGA_W      = 10;
    localparam int STARTUP_W  = 12;
    localparam logic [ADDR_W-1:0] ADDR_OPER    = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_CTRL    = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_CLAMP   = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_VGA     = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_STARTUP = 3'd4;
    localparam logic [CLAMP_W-1:0] CLAMP_DEF   = 8'd128;
    localparam logic [WORD_W-1:0]  STARTUP_VAL = 12'h838;
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
endpackage

// File: rtl/ad9945_serial_rx_if.sv
// ad9945_serial_rx_if: serial pins plus decoded register/write-report bus (AD9945_STARTUP_CHECK_EN adds startup_err)
interface ad9945_serial_rx_if;
    import ad9945_pkg::*;
    logic SDATA;
    logic SCK;
    logic SL;
    logic [OPER_W-1:0]    oper;
    logic [CTRL_W-1:0]    ctrl;
    logic [CLAMP_W-1:0]   clamp;
    logic [VGA_W-1:0]     vga_gain;
    logic [STARTUP_W-1:0] startup;
    logic                 wr_strobe;
    logic [ADDR_W-1:0]    wr_addr;
    logic [WORD_W-1:0]    wr_data;
    logic                 frame_done;
    logic                 frame_err;
`ifdef AD9945_STARTUP_CHECK_EN
    logic                 startup_err;
`endif
    modport slave (
        input  SDATA, SCK, SL,
`ifdef AD9945_STARTUP_CHECK_EN
        output startup_err,
`endif
        output oper, ctrl, clamp, vga_gain, startup,
        output wr_strobe, wr_addr, wr_data, frame_done, frame_err
    );
    modport master (
        output SDATA, SCK, SL,
`ifdef AD9945_STARTUP_CHECK_EN
        input  startup_err,
`endif
        input  oper, ctrl, clamp, vga_gain, startup,
        input  wr_strobe, wr_addr, wr_data, frame_done, frame_err
    );
endinterface

// File: rtl/ad9945_in_sync.sv
// ad9945_in_sync: synchronizer chains for SCK/SL/SDATA with rising-edge detects on SCK and SL
module ad9945_in_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sck,
    input  logic sl,
    input  logic sdata,
    output logic sck_rise,
    output logic sl_rise,
    output logic sl_s,
    output logic sdata_s
);
    logic [STAGES-1:0] sck_q, sl_q, sd_q;
    logic sck_d, sl_d;
    // SL resets low so a frame in progress at reset release is not mistaken for an idle line
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sck_q <= '0;
            sl_q  <= '0;
            sd_q  <= '0;
            sck_d <= 1'b0;
            sl_d  <= 1'b0;
        end else begin
            sck_q <= {sck_q[STAGES-2:0], sck};
            sl_q  <= {sl_q[STAGES-2:0], sl};
            sd_q  <= {sd_q[STAGES-2:0], sdata};
            sck_d <= sck_q[STAGES-1];
            sl_d  <= sl_q[STAGES-1];
        end
    assign sck_rise = sck_q[STAGES-1] & ~sck_d;
    assign sl_rise  = sl_q[STAGES-1] & ~sl_d;
    assign sl_s     = sl_q[STAGES-1];
    assign sdata_s  = sd_q[STAGES-1];
endmodule

// File: rtl/ad9945_serial_rx.sv
// ad9945_serial_rx: AD9945 3-wire serial write receiver with shadow registers (option AD9945_STARTUP_CHECK_EN)
module ad9945_serial_rx
    import ad9945_pkg::*;
#(
    parameter int                  SYNC_STAGES   = 2,
    parameter logic [CLAMP_W-1:0]  CLAMP_DEFAULT = CLAMP_DEF
`ifdef AD9945_STARTUP_CHECK_EN
    , parameter logic [WORD_W-1:0] STARTUP_EXPECT = STARTUP_VAL
`endif
) (
    input logic              sys_clk,
    input logic              rst,
    ad9945_serial_rx_if.slave bus
);
    state_t st, nxt;
    logic sck_rise, sl_rise, sl_s, sdata_s;
    logic armed, words, bit_in, word_done, clean_end;
    logic [1:0] addr_cnt, ash;
    logic [3:0] bit_cnt;
    logic [10:0] sh;
    logic [ADDR_W-1:0] cur_addr, wr_addr;
    logic [WORD_W-1:0] word, wr_data;
    logic [OPER_W-1:0] oper;
    logic [CTRL_W-1:0] ctrl;
    logic [CLAMP_W-1:0] clamp;
    logic [VGA_W-1:0] vga_gain;
    logic [STARTUP_W-1:0] startup;
    logic wr_strobe, frame_done, frame_err;

    ad9945_in_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk(sys_clk), .rst(rst), .sck(bus.SCK), .sl(bus.SL), .sdata(bus.SDATA),
        .sck_rise(sck_rise), .sl_rise(sl_rise), .sl_s(sl_s), .sdata_s(sdata_s)
    );

    // sl_rise implies sl_s high, so an SL rise always beats a coincident SCK rise
    assign bit_in    = sck_rise & ~sl_s;
    assign word_done = st == DATA && bit_in && bit_cnt == 4'd11;
    assign word      = {sdata_s, sh};
    assign clean_end = st == DATA && bit_cnt == 4'd0 && words;

    // state register
    always_ff @(posedge sys_clk or posedge rst)
        if (rst) st <= IDLE;
        else     st <= nxt;

    // next state: a frame starts only once SL has been seen high since reset
    always_comb begin
        nxt = st;
        if (st != IDLE && sl_rise) nxt = IDLE;
        else if (st == IDLE && armed && !sl_s) nxt = ADDR;
        else if (st == ADDR && bit_in && addr_cnt == 2'd2) nxt = DATA;
    end

    // bit shifting, write reporting and shadow register updates
    always_ff @(posedge sys_clk or posedge rst)
        if (rst) begin
            armed <= 1'b0; words <= 1'b0; addr_cnt <= '0; ash <= '0; bit_cnt <= '0; sh <= '0;
            cur_addr <= '0; wr_addr <= '0; wr_data <= '0;
            wr_strobe <= 1'b0; frame_done <= 1'b0; frame_err <= 1'b0;
            oper <= '0; ctrl <= '0; clamp <= CLAMP_DEFAULT; vga_gain <= '0; startup <= '0;
        end else begin
            armed      <= armed | sl_s;
            wr_strobe  <= word_done;
            frame_done <= st != IDLE && sl_rise && clean_end;
            frame_err  <= st != IDLE && sl_rise && !clean_end;
            if (st == IDLE) begin
                addr_cnt <= '0;
                bit_cnt  <= '0;
                words    <= 1'b0;
            end
            if (st == ADDR && bit_in) begin
                ash      <= {sdata_s, ash[1]};
                addr_cnt <= addr_cnt + 2'd1;
                if (addr_cnt == 2'd2) cur_addr <= {sdata_s, ash};
            end
            if (st == DATA && bit_in) begin
                sh      <= {sdata_s, sh[10:1]};
                bit_cnt <= word_done ? 4'd0 : bit_cnt + 4'd1;
            end
            if (word_done) begin
                wr_addr  <= cur_addr;
                wr_data  <= word;
                cur_addr <= cur_addr + 3'd1;
                words    <= 1'b1;
                case (cur_addr)
                    ADDR_OPER:    oper     <= word[OPER_W-1:0];
                    ADDR_CTRL:    ctrl     <= word[CTRL_W-1:0];
                    ADDR_CLAMP:   clamp    <= word[CLAMP_W-1:0];
                    ADDR_VGA:     vga_gain <= word[VGA_W-1:0];
                    ADDR_STARTUP: startup  <= word[STARTUP_W-1:0];
                    default: ;
                endcase
            end
        end

`ifdef AD9945_STARTUP_CHECK_EN
    logic startup_err;
    // flag a startup word that differs from the expected value, aligned with wr_strobe
    always_ff @(posedge sys_clk or posedge rst)
        if (rst) startup_err <= 1'b0;
        else     startup_err <= word_done && cur_addr == ADDR_STARTUP && word != STARTUP_EXPECT;
    assign bus.startup_err = startup_err;
`endif

    assign bus.oper       = oper;
    assign bus.ctrl       = ctrl;
    assign bus.clamp      = clamp;
    assign bus.vga_gain   = vga_gain;
    assign bus.startup    = startup;
    assign bus.wr_strobe  = wr_strobe;
    assign bus.wr_addr    = wr_addr;
    assign bus.wr_data    = wr_data;
    assign bus.frame_done = frame_done;
    assign bus.frame_err  = frame_err;
endmodule

// File: tb/tb_ad9945_serial_rx.sv
// tb_ad9945_serial_rx: scoreboard bench for the AD9945 serial receiver
module tb_ad9945_serial_rx;
    import ad9945_pkg::*;
    logic sys_clk, rst;
    ad9945_serial_rx_if bus();
    ad9945_serial_rx dut (.sys_clk(sys_clk), .rst(rst), .bus(bus));

    int tests, fails, nstrobe, ndone, nerr, nserr, nbits;
    logic fb [0:127];
    logic [11:0] wd [0:7];
    logic [14:0] sb [$];

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        bus.SCK = 1'b0;
        forever #80 bus.SCK = ~bus.SCK;
    end

    task automatic build(input logic [2:0] a, input int nw, input int extra);
        nbits = 3 + 12 * nw + extra;
        for (int i = 0; i < 3; i++) fb[i] = a[i];
        for (int i = 0; i < 12 * nw + extra; i++) fb[3 + i] = wd[i / 12][i % 12];
        for (int k = 0; k < nw; k++) sb.push_back({3'(a + k), wd[k]});
    endtask

    task automatic drive_bits(input int n, input bit close);
        for (int i = 0; i < n; i++) begin
            @(negedge bus.SCK);
            bus.SL = 1'b0;
            bus.SDATA = fb[i];
        end
        if (close) begin
            @(negedge bus.SCK);
            bus.SL = 1'b1;
        end
    endtask

    task automatic monitor(input int cycles);
        logic [14:0] exp;
        nstrobe = 0; ndone = 0; nerr = 0; nserr = 0;
        repeat (cycles) begin
            @(negedge sys_clk);
            if (bus.wr_strobe) begin
                nstrobe++;
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_strobe got addr=%0d data=%h, none expected", bus.wr_addr, bus.wr_data);
                end else begin
                    exp = sb.pop_front();
                    if ({bus.wr_addr, bus.wr_data} !== exp) begin
                        fails++;
                        $display("FAIL strobe got addr=%0d data=%h exp addr=%0d data=%h", bus.wr_addr, bus.wr_data, exp[14:12], exp[11:0]);
                    end
                end
            end
            if (bus.frame_done) ndone++;
            if (bus.frame_err) nerr++;
`ifdef AD9945_STARTUP_CHECK_EN
            if (bus.startup_err) nserr++;
`endif
        end
    endtask

    task automatic run_frame(input logic [2:0] a, input int nw, input int extra);
        build(a, nw, extra);
        fork
            drive_bits(nbits, 1'b1);
            monitor((nbits + 3) * 16 + 20);
        join
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL missing_strobes got %0d left exp 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.SL = 1'b1; bus.SDATA = 1'b0;
        repeat (4) @(negedge sys_clk);
        tests++;
        if ({bus.oper, bus.ctrl, bus.clamp, bus.vga_gain, bus.startup} !== {7'h0, 7'h0, 8'd128, 10'h0, 12'h0}) begin
            fails++;
            $display("FAIL reset_regs got %h %h %h %h %h", bus.oper, bus.ctrl, bus.clamp, bus.vga_gain, bus.startup);
        end
        tests++;
        if ({bus.wr_strobe, bus.frame_done, bus.frame_err, bus.wr_addr, bus.wr_data} !== 18'h0) begin
            fails++;
            $display("FAIL reset_outs got strobe=%b done=%b err=%b addr=%0d data=%h exp all 0",
                     bus.wr_strobe, bus.frame_done, bus.frame_err, bus.wr_addr, bus.wr_data);
        end
        rst = 1'b0;
        monitor(320);
        tests++;
        if (nstrobe != 0 || ndone != 0 || nerr != 0) begin
            fails++;
            $display("FAIL idle_sck got strobes=%0d done=%0d err=%0d exp 0", nstrobe, ndone, nerr);
        end
        tests++;
        if (bus.clamp !== 8'd128) begin
            fails++;
            $display("FAIL idle_clamp got %h exp 80", bus.clamp);
        end
    endtask

    task automatic test_full_frame();
        wd[0] = 12'h005; wd[1] = 12'h012; wd[2] = 12'h040; wd[3] = 12'h2AB; wd[4] = 12'h838;
        run_frame(3'd0, 5, 0);
        tests++;
        if (nstrobe != 5 || ndone != 1 || nerr != 0) begin
            fails++;
            $display("FAIL full_counts got strobes=%0d done=%0d err=%0d exp 5 1 0", nstrobe, ndone, nerr);
        end
        tests++;
        if ({bus.oper, bus.ctrl, bus.clamp, bus.vga_gain, bus.startup} !== {7'h05, 7'h12, 8'h40, 10'h2AB, 12'h838}) begin
            fails++;
            $display("FAIL full_regs got %h %h %h %h %h exp 05 12 40 2ab 838", bus.oper, bus.ctrl, bus.clamp, bus.vga_gain, bus.startup);
        end
    endtask

    task automatic test_partial();
        wd[0] = 12'hA5A; wd[1] = 12'h07F;
        run_frame(3'd0, 1, 5);
        tests++;
        if (nstrobe != 1 || ndone != 0 || nerr != 1) begin
            fails++;
            $display("FAIL partial_counts got strobes=%0d done=%0d err=%0d exp 1 0 1", nstrobe, ndone, nerr);
        end
        tests++;
        if ({bus.oper, bus.ctrl} !== {7'h5A, 7'h12}) begin
            fails++;
            $display("FAIL partial_regs got oper=%h ctrl=%h exp 5a 12", bus.oper, bus.ctrl);
        end
    endtask

    task automatic test_wrap();
        wd[0] = 12'h111; wd[1] = 12'h222; wd[2] = 12'h3C5;
        run_frame(3'd6, 3, 0);
        tests++;
        if (nstrobe != 3 || ndone != 1 || nerr != 0) begin
            fails++;
            $display("FAIL wrap_counts got strobes=%0d done=%0d err=%0d exp 3 1 0", nstrobe, ndone, nerr);
        end
        tests++;
        if ({bus.oper, bus.ctrl, bus.clamp, bus.vga_gain, bus.startup} !== {7'h45, 7'h12, 8'h40, 10'h2AB, 12'h838}) begin
            fails++;
            $display("FAIL wrap_regs got %h %h %h %h %h exp 45 12 40 2ab 838", bus.oper, bus.ctrl, bus.clamp, bus.vga_gain, bus.startup);
        end
    endtask

`ifdef AD9945_STARTUP_CHECK_EN
    task automatic test_startup_check();
        wd[0] = 12'h800;
        run_frame(3'd4, 1, 0);
        tests++;
        if (nserr != 1 || bus.startup !== 12'h800) begin
            fails++;
            $display("FAIL startup_bad got pulses=%0d startup=%h exp 1 800", nserr, bus.startup);
        end
        wd[0] = 12'h838;
        run_frame(3'd4, 1, 0);
        tests++;
        if (nserr != 0 || bus.startup !== 12'h838) begin
            fails++;
            $display("FAIL startup_good got pulses=%0d startup=%h exp 0 838", nserr, bus.startup);
        end
    endtask
`endif

    task automatic test_reset_mid_frame();
        wd[0] = 12'h0AA; wd[1] = 12'h155; wd[2] = 12'hFFF;
        build(3'd0, 2, 3);
        fork
            drive_bits(30, 1'b0);
            monitor(32 * 16);
        join
        tests++;
        if (nstrobe != 2 || sb.size() != 0) begin
            fails++;
            $display("FAIL premid_strobes got %0d left=%0d exp 2 0", nstrobe, sb.size());
            sb.delete();
        end
        rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        tests++;
        if ({bus.oper, bus.ctrl, bus.clamp, bus.vga_gain, bus.startup, bus.wr_strobe} !== {7'h0, 7'h0, 8'd128, 10'h0, 12'h0, 1'b0}) begin
            fails++;
            $display("FAIL midreset_regs got %h %h %h %h %h strobe=%b", bus.oper, bus.ctrl, bus.clamp, bus.vga_gain, bus.startup, bus.wr_strobe);
        end
        rst = 1'b0;
        for (int i = 0; i < 24; i++) fb[i] = 1'b1;
        fork
            drive_bits(24, 1'b0);
            monitor(26 * 16);
        join
        tests++;
        if (nstrobe != 0 || ndone != 0 || nerr != 0) begin
            fails++;
            $display("FAIL postreset_quiet got strobes=%0d done=%0d err=%0d exp 0", nstrobe, ndone, nerr);
        end
        fork
            begin @(negedge bus.SCK); bus.SL = 1'b1; end
            monitor(60);
        join
        tests++;
        if (nstrobe != 0 || ndone != 0 || nerr != 0) begin
            fails++;
            $display("FAIL postreset_slrise got strobes=%0d done=%0d err=%0d exp 0", nstrobe, ndone, nerr);
        end
        wd[0] = 12'h123; wd[1] = 12'h456; wd[2] = 12'h789; wd[3] = 12'hABC; wd[4] = 12'hDEF;
        run_frame(3'd0, 5, 0);
        tests++;
        if (nstrobe != 5 || ndone != 1 || nerr != 0) begin
            fails++;
            $display("FAIL newframe_counts got strobes=%0d done=%0d err=%0d exp 5 1 0", nstrobe, ndone, nerr);
        end
        tests++;
        if ({bus.oper, bus.ctrl, bus.clamp, bus.vga_gain, bus.startup} !== {7'h23, 7'h56, 8'h89, 10'h2BC, 12'hDEF}) begin
            fails++;
            $display("FAIL newframe_regs got %h %h %h %h %h exp 23 56 89 2bc def", bus.oper, bus.ctrl, bus.clamp, bus.vga_gain, bus.startup);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_full_frame();
        test_partial();
        test_wrap();
`ifdef AD9945_STARTUP_CHECK_EN
        test_startup_check();
`endif
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
